// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, shift schedule and FSM states.
package des_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Entries are 1-based FIPS bit numbers of the 64-bit key (bit 1 = MSB)
    localparam int unsigned PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Entries are 1-based bit numbers of the 56-bit C||D value (bit 1 = MSB)
    localparam int unsigned PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit r set means round r uses a single-bit rotation, otherwise two bits
    localparam logic [15:0] SHIFT_ONE = 16'h8103;

endpackage

// File: rtl/des_key_schedule_if.sv
// Load request and subkey stream signals between a key consumer and the schedule.
interface des_key_schedule_if;

    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        out_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        out_valid;
    logic        busy;
    logic        done;

    modport master (
        output start, decrypt, key, out_ready,
        input  subkey, round, out_valid, busy, done
    );

    modport slave (
        input  start, decrypt, key, out_ready,
        output subkey, round, out_valid, busy, done
    );

endinterface

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit C||D register into a 48-bit subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int i = 0; i < 48; i++) begin
            subkey[47 - i] = cd[56 - PC2_TABLE[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: loads PC-1 of the key and streams 16 subkeys in
// encrypt or decrypt order under a valid/ready handshake.
module des_key_schedule
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    des_key_schedule_if.slave  bus
);

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        decrypt_q, decrypt_d;
    logic        done_q, done_d;
    logic [55:0] pc1_key;
    logic [3:0]  round_up;
    logic [3:0]  round_down;

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic left,
                                          input logic two);
        case ({left, two})
            2'b10:   rot28 = {x[26:0], x[27]};
            2'b11:   rot28 = {x[25:0], x[27:26]};
            2'b00:   rot28 = {x[0], x[27:1]};
            default: rot28 = {x[1:0], x[27:2]};
        endcase
    endfunction

    always_comb begin
        pc1_key = '0;
        for (int i = 0; i < 56; i++) begin
            pc1_key[55 - i] = bus.key[64 - PC1_TABLE[i]];
        end
    end

    assign round_up   = round_q + 4'd1;
    assign round_down = round_q - 4'd1;

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        round_d   = round_q;
        decrypt_d = decrypt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    decrypt_d = bus.decrypt;
                    // Decrypt starts at round 15, whose C/D equal unrotated PC-1 (28 total shifts)
                    if (bus.decrypt) begin
                        c_d     = pc1_key[55:28];
                        d_d     = pc1_key[27:0];
                        round_d = 4'd15;
                    end else begin
                        c_d     = rot28(pc1_key[55:28], 1'b1, 1'b0);
                        d_d     = rot28(pc1_key[27:0], 1'b1, 1'b0);
                        round_d = 4'd0;
                    end
                end
            end
            RUN: begin
                if (bus.out_ready) begin
                    if (decrypt_q ? (round_q == 4'd0) : (round_q == 4'd15)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (decrypt_q) begin
                        round_d = round_down;
                        c_d     = rot28(c_q, 1'b0, ~SHIFT_ONE[round_q]);
                        d_d     = rot28(d_q, 1'b0, ~SHIFT_ONE[round_q]);
                    end else begin
                        round_d = round_up;
                        c_d     = rot28(c_q, 1'b1, ~SHIFT_ONE[round_up]);
                        d_d     = rot28(d_q, 1'b1, ~SHIFT_ONE[round_up]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            round_q   <= '0;
            decrypt_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            round_q   <= round_d;
            decrypt_q <= decrypt_d;
            done_q    <= done_d;
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (bus.subkey)
    );

    assign bus.round     = round_q;
    assign bus.out_valid = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 Parameters: none; all widths are fixed by DES.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  load request; sampled only in IDLE.
REQ-005 decrypt  input  1  sampled with start; 1 = emit subkeys in order round 15 down to 0.
REQ-006 key  input  64  DES key, FIPS bit 1 = key[63]; parity bits 8,16,...,64 are ignored.
REQ-007 out_ready  input  1  consumer accepts subkey when high with out_valid.
REQ-008 subkey  output  48  current round key, PC-2 bit 1 = subkey[47].
REQ-009 round  output  4  0-based index of the current subkey.
REQ-010 out_valid  output  1  subkey/round valid.
REQ-011 busy  output  1  high from the cycle after accepted start until the last subkey is accepted.
REQ-012 done  output  1  one-cycle pulse in the cycle after the 16th subkey is accepted.

Function
REQ-013 Shift schedule: shift(r) = 1 for r in {0,1,8,15}, else 2.
REQ-014 C and D are 28-bit registers; subkey = PC2(C,D), combinational from the registers.
REQ-015 FSM states: IDLE, RUN.
REQ-016 IDLE with start=1: C,D load from PC1(key). Encrypt loads rotl(PC1,1) and round=0. Decrypt loads PC1 unrotated and round=15. The FSM then enters RUN.
REQ-017 In RUN, out_valid=1 and busy=1.
REQ-018 Encrypt accept (out_valid & out_ready, round=r<15): round <= r+1; C,D <= rotl by shift(r+1).
REQ-019 Decrypt accept (round=r>0): round <= r-1; C,D <= rotr by shift(r).
REQ-020 Accept of the final subkey (encrypt r=15, decrypt r=0): go to IDLE; done=1 in the next cycle; C,D are held.
REQ-021 Latency: start accepted at edge t gives out_valid at t+1. With out_ready held high, subkeys appear in 16 consecutive cycles, and busy is low from t+17.
REQ-022 out_ready=0 in RUN: subkey, round and out_valid hold stable; no state change.
REQ-023 start while in RUN is ignored, including in the cycle of the final accept; start is sampled again in IDLE.
REQ-024 In IDLE: out_valid=0, busy=0; subkey and round are don't-care but deterministic (held registers).
REQ-025 Rotations are circular within each 28-bit half; C and D never exchange bits.

Reset
REQ-026 rst_n low asynchronously forces IDLE, C=D=0, round=0, out_valid=0, busy=0, done=0.
REQ-027 Reset asserted mid-RUN aborts the schedule; no further subkey or done is produced.
REQ-028 After rst_n rises, the first start is honoured at the first rising edge where rst_n is high.

Structure
REQ-029 The shared package des_pkg holds the PC-1 and PC-2 tables, the shift-schedule constant, and the FSM state encodings.
REQ-030 One combinational sub-module, des_pc2 (56-bit in, 48-bit out), implements PC-2. PC-1 and the rotators are inline in des_key_schedule.
REQ-031 There is no second clock, no latch, and no combinational path from out_ready to subkey.

Verification
REQ-032 Encrypt run: key=0x133457799BBCDFF1, decrypt=0, out_ready=1. Required response: round 0 subkey=0x1B02EFFC7072; round 15 subkey=0xCB3D8B0E17F5; 16 consecutive valids; done one cycle after the last valid.
REQ-033 Decrypt run: same key, decrypt=1. Required response: first output round=15, subkey=0xCB3D8B0E17F5; last output round=0, subkey=0x1B02EFFC7072.
REQ-034 Backpressure: drop out_ready for 3 cycles at round 5. Required response: subkey and round frozen at 5; the full sequence matches REQ-032's golden 16-key list.
REQ-035 Start during RUN with a different key. Required response: no effect; output sequence unchanged; after done, a new start produces the new key's schedule.
REQ-036 Reset mid-run: assert rst_n=0 asynchronously at round 7, between edges. Required response: out_valid, busy and done go to 0 immediately; no done; a restart reproduces round 0 subkey 0x1B02EFFC7072.
REQ-037 Parity invariance: key 0x133457799BBCDFF1 with all parity bits flipped (XOR 0x0101010101010101). Required response: identical 16 subkeys.
